// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline datapath.
// The master side drives the hazard inputs; the slave side is the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              start_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rt_i;
    logic              idex_memread_i;
    logic [REG_AW-1:0] idex_rt_i;
    logic              branch_taken_i;
    logic              mem_busy_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;
    logic              idex_flush_o;
    logic              pipe_hold_o;
    logic [CNT_W-1:0]  stall_cycles_o;

    modport master (
        output start_i, id_rs_i, id_rt_i, id_use_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o,
               stall_cycles_o
    );

    modport slave (
        input  start_i, id_rs_i, id_rt_i, id_use_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o,
               stall_cycles_o
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use stall bubbles, taken-branch IF/ID flush, memory-busy freeze.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_unit #(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int IGNORE_R0      = 1,
    parameter int CNT_W          = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t     state_r;
    logic [2:0] cnt_r;

    logic match_rs_s;
    logic match_rt_s;
    logic dest_ok_s;
    logic hazard_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic pipe_hold_s;

    // Load-use hazard detection between the load in EX and the sources of the ID instruction
    always_comb begin
        match_rs_s = (bus.id_rs_i == bus.idex_rt_i);
        match_rt_s = bus.id_use_rt_i & (bus.id_rt_i == bus.idex_rt_i);
        if (IGNORE_R0 != 0) begin
            dest_ok_s = (bus.idex_rt_i != {REG_AW{1'b0}});
        end else begin
            dest_ok_s = 1'b1;
        end
        hazard_s = (state_r == ST_RUN) & bus.idex_memread_i & dest_ok_s & (match_rs_s | match_rt_s);
    end

    // Pipeline control outputs; a branch is dropped while a stall is pending since its operand is stale
    always_comb begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        ifid_flush_s = 1'b1;
        idex_flush_s = 1'b1;
        pipe_hold_s  = 1'b0;
        if (!bus.start_i || (state_r == ST_IDLE)) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            pipe_hold_s  = 1'b0;
        end else if (bus.mem_busy_i) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b0;
            pipe_hold_s  = 1'b1;
        end else if ((state_r == ST_STALL) || hazard_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b1;
            pipe_hold_s  = 1'b0;
        end else if (bus.branch_taken_i) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b0;
            pipe_hold_s  = 1'b0;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b0;
            pipe_hold_s  = 1'b0;
        end
    end

    // Control FSM with the remaining-bubble countdown; memory busy freezes both
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else if (!bus.start_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_RUN;
                    cnt_r   <= 3'd0;
                end
                ST_RUN: begin
                    if (bus.mem_busy_i) begin
                        state_r <= ST_RUN;
                        cnt_r   <= cnt_r;
                    end else if (hazard_s && (LOAD_USE_STALL > 1)) begin
                        state_r <= ST_STALL;
                        cnt_r   <= 3'(LOAD_USE_STALL - 1);
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= 3'd0;
                    end
                end
                ST_STALL: begin
                    if (bus.mem_busy_i) begin
                        state_r <= ST_STALL;
                        cnt_r   <= cnt_r;
                    end else if (cnt_r <= 3'd1) begin
                        state_r <= ST_RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        state_r <= ST_STALL;
                        cnt_r   <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.pc_write_o   = pc_write_s;
    assign bus.ifid_write_o = ifid_write_s;
    assign bus.ifid_flush_o = ifid_flush_s;
    assign bus.idex_flush_o = idex_flush_s;
    assign bus.pipe_hold_o  = pipe_hold_s;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of running cycles in which the PC was held back
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.start_i && (state_r != ST_IDLE) && !pc_write_s &&
                     (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cycles_o = stall_cnt_r;
`else
    assign bus.stall_cycles_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: instance A uses LOAD_USE_STALL=1, instance B uses 3.
module tb_hazard_ctrl_unit;

    localparam logic [4:0] C_IDLE  = 5'b00110; // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_BR    = 5'b11100;
    localparam logic [4:0] C_HOLD  = 5'b00001;

    typedef struct {
        int          sel;
        bit          chk;
        logic [4:0]  ctl;
        logic [15:0] perf;
        string       name;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_tests;
    int   n_fail;
    int   perf_m [2];
    exp_t q [$];
    exp_t mon_e;
    logic [4:0]  act_ctl;
    logic [15:0] act_perf;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_b ();

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(1), .IGNORE_R0(1), .CNT_W(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (if_a)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(3), .IGNORE_R0(1), .CNT_W(16)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus on the selected instance and queue its expected response
    task automatic step(input int sel, input bit chk, input logic rst, input logic start,
                        input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                        input logic memread, input logic [4:0] ex_rt, input logic br,
                        input logic busy, input logic [4:0] ctl, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            rst_a = rst; if_a.start_i = start; if_a.id_rs_i = rs; if_a.id_rt_i = rt;
            if_a.id_use_rt_i = use_rt; if_a.idex_memread_i = memread; if_a.idex_rt_i = ex_rt;
            if_a.branch_taken_i = br; if_a.mem_busy_i = busy;
        end else begin
            rst_b = rst; if_b.start_i = start; if_b.id_rs_i = rs; if_b.id_rt_i = rt;
            if_b.id_use_rt_i = use_rt; if_b.idex_memread_i = memread; if_b.idex_rt_i = ex_rt;
            if_b.branch_taken_i = br; if_b.mem_busy_i = busy;
        end
        e.sel  = sel;
        e.chk  = chk;
        e.ctl  = ctl;
`ifdef HAZARD_PERF_EN
        e.perf = 16'(perf_m[sel]);
`else
        e.perf = 16'd0;
`endif
        e.name = name;
        q.push_back(e);
        if (!rst) begin
            perf_m[sel] = 0;
        end else if (start && !ctl[4] && !ctl[2]) begin
            perf_m[sel] = perf_m[sel] + 1;
        end
    endtask

    // Monitor: pop the queued expectation for this cycle and compare away from the clock edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e.sel == 0) begin
                act_ctl  = {if_a.pc_write_o, if_a.ifid_write_o, if_a.ifid_flush_o,
                            if_a.idex_flush_o, if_a.pipe_hold_o};
                act_perf = if_a.stall_cycles_o;
            end else begin
                act_ctl  = {if_b.pc_write_o, if_b.ifid_write_o, if_b.ifid_flush_o,
                            if_b.idex_flush_o, if_b.pipe_hold_o};
                act_perf = if_b.stall_cycles_o;
            end
            if (mon_e.chk) begin
                n_tests = n_tests + 1;
                if (act_ctl !== mon_e.ctl) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s ctl: got %b want %b", mon_e.name, act_ctl, mon_e.ctl);
                end
                n_tests = n_tests + 1;
                if (act_perf !== mon_e.perf) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s stall_cycles: got %0d want %0d", mon_e.name, act_perf, mon_e.perf);
                end
            end
        end
    end

    initial begin
        int waited;
        n_tests = 0;
        n_fail  = 0;
        perf_m[0] = 0;
        perf_m[1] = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        if_a.start_i = 1'b0; if_a.id_rs_i = 5'd0; if_a.id_rt_i = 5'd0; if_a.id_use_rt_i = 1'b0;
        if_a.idex_memread_i = 1'b0; if_a.idex_rt_i = 5'd0; if_a.branch_taken_i = 1'b0; if_a.mem_busy_i = 1'b0;
        if_b.start_i = 1'b0; if_b.id_rs_i = 5'd0; if_b.id_rt_i = 5'd0; if_b.id_use_rt_i = 1'b0;
        if_b.idex_memread_i = 1'b0; if_b.idex_rt_i = 5'd0; if_b.branch_taken_i = 1'b0; if_b.mem_busy_i = 1'b0;

        // Instance A, LOAD_USE_STALL=1
        step(0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "a_rst0");
        step(0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "a_rst1");
        step(0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "a_start");
        step(0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd6, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, C_NORM,  "a_run_noload");
        step(0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, C_STALL, "a_lu_rs");
        step(0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, C_NORM,  "a_lu_done");
        step(0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM,  "a_r0_ignored");
        step(0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_NORM,  "a_sw_no_rt");
        step(0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_STALL, "a_rt_match");
        step(0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, C_STALL, "a_br_in_hazard");
        step(0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, C_BR,    "a_br_taken");
        step(0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, C_NORM,  "a_after_br");
        step(0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd8, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, C_IDLE,  "a_stop");
        step(0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "a_idle_perf");

        // Instance B, LOAD_USE_STALL=3
        step(1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_rst0");
        step(1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_rst1");
        step(1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_start");
        step(1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd6, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, C_NORM,  "b_run");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, C_STALL, "b_lu_run");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, C_STALL, "b_lu_cnt2_br");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, "b_lu_cnt1");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  "b_lu_done");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, C_STALL, "b_hz2_run");
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, C_HOLD, "b_busy_hold");
        end
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, "b_busy_cnt2");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, "b_busy_cnt1");
        step(1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  "b_busy_done");
        step(1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL, "b_hz3_run");
        step(1, 1'b1, 1'b1, 1'b0, 5'd9, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_stop_in_stall");
        step(1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_restart");
        step(1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  "b_no_leftover");
        step(1, 1'b1, 1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, C_STALL, "b_hz4_run");
        step(1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, "b_rst_in_stall");
        step(1, 1'b1, 1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  "b_after_rst");
        step(1, 1'b1, 1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  "b_run_again");

        waited = 0;
        while ((q.size() > 0) && (waited < 10)) begin
            @(posedge clk);
            waited = waited + 1;
        end
        if (q.size() > 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
